// File: rtl/adc_spi_streamer_pkg.sv
// Shared definitions for the ADC SPI streamer: FSM states and fixed widths.
package adc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CNV,
      ST_WAIT_BUSY,
      ST_SHIFT,
      ST_PUSH
   } adc_state_t;

   // Width of every word presented on the output stream.
   localparam int SampleWidth = 32;

   // Flops between the asynchronous ADC BUSY pin and the FSM.
   localparam int SyncStages = 2;

   // Cycles spent in WAIT_BUSY before a low BUSY is believed; covers the
   // synchroniser lag right after CNV drops.
   localparam int BusySettleCycles = 3;

endpackage

// File: rtl/adc_spi_streamer_if.sv
// AXI-Stream data channel between the streamer and the packetizer.
interface adc_spi_streamer_if;
   import adc_pkg::*;

   logic [SampleWidth-1:0] tdata;
   logic                   tvalid;
   logic                   tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/adc_spi_streamer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word is always on dout.
module sync_fifo #(
   parameter int Width = 32,
   parameter int Depth = 4
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     push,
   input  logic [Width-1:0]         din,
   output logic                     full,
   input  logic                     pop,
   output logic [Width-1:0]         dout,
   output logic                     empty,
   output logic [$clog2(Depth):0]   level
);

   localparam int AW = $clog2(Depth);

   logic [Width-1:0] mem [Depth];
   logic [AW:0]      wr_cnt;
   logic [AW:0]      rd_cnt;
   logic             do_pop;
   logic             do_push;

   assign level   = wr_cnt - rd_cnt;
   assign full    = (level == (AW+1)'(Depth));
   assign empty   = (level == '0);
   assign dout    = mem[rd_cnt[AW-1:0]];
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push && (!full || do_pop);

   // Read/write counters carry one extra bit so full and empty are distinguishable.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         if (do_push) wr_cnt <= wr_cnt + 1'b1;
         if (do_pop)  rd_cnt <= rd_cnt + 1'b1;
      end
   end

   // Storage array; contents need no reset since the counters define validity.
   always_ff @(posedge aclk) begin
      if (do_push) mem[wr_cnt[AW-1:0]] <= din;
   end

endmodule

// File: rtl/adc_spi_streamer.sv
// Conversion-start / SPI-read ADC front end feeding an AXI-Stream FIFO.
module adc_spi_streamer
   import adc_pkg::*;
#(
   parameter int DataBits    = 24,
   parameter int SckDiv      = 2,
   parameter int CnvCycles   = 4,
   parameter int BusyTimeout = 1024,
   parameter int FifoDepth   = 4
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          enable,
   input  logic                          trigger,
   output logic                          adc_cnv,
   input  logic                          adc_busy,
   output logic                          spi_cs_n,
   output logic                          spi_sck,
   input  logic                          spi_sdo,
   adc_spi_streamer_if.master            m_axis_data,
   output logic [31:0]                   dropped_count,
   output logic                          busy_timeout,
   output logic [$clog2(FifoDepth):0]    fifo_level
);

   localparam int CntMax0 = (BusyTimeout > CnvCycles) ? BusyTimeout : CnvCycles;
   localparam int CntMax  = (CntMax0 > BusySettleCycles) ? CntMax0 : BusySettleCycles + 1;
   localparam int CntW    = $clog2(CntMax + 1);
   localparam int PhW     = $clog2(2 * SckDiv + 1);
   localparam int BitW    = $clog2(DataBits + 1);

   adc_state_t              state;
   logic [CntW-1:0]         cnt;
   logic [PhW-1:0]          phase;
   logic [BitW-1:0]         bit_cnt;
   logic [DataBits-1:0]     shreg;
   logic [SyncStages-1:0]   busy_sync;
   logic                    busy_s;

   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [SampleWidth-1:0]  push_data;
   logic [SampleWidth-1:0]  fifo_dout;

   assign busy_s    = busy_sync[SyncStages-1];
   assign push_data = SampleWidth'($signed(shreg));
   assign fifo_push = (state == ST_PUSH);
   assign fifo_pop  = !fifo_empty && m_axis_data.tready;

   assign m_axis_data.tvalid = !fifo_empty;
   assign m_axis_data.tdata  = fifo_dout;

   // Two-flop synchroniser for the asynchronous BUSY pin.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) busy_sync <= '0;
      else          busy_sync <= {busy_sync[SyncStages-2:0], adc_busy};
   end

   // Conversion / SPI read sequencer with registered ADC-side outputs.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= ST_IDLE;
         adc_cnv       <= 1'b0;
         spi_cs_n      <= 1'b1;
         spi_sck       <= 1'b0;
         cnt           <= '0;
         phase         <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         busy_timeout  <= 1'b0;
         dropped_count <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (trigger && enable) begin
                  state   <= ST_CNV;
                  adc_cnv <= 1'b1;
                  cnt     <= '0;
               end
            end
            ST_CNV: begin
               if (cnt == CntW'(CnvCycles - 1)) begin
                  adc_cnv <= 1'b0;
                  cnt     <= '0;
                  state   <= ST_WAIT_BUSY;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_WAIT_BUSY: begin
               if (!busy_s && cnt >= CntW'(BusySettleCycles)) begin
                  state    <= ST_SHIFT;
                  spi_cs_n <= 1'b0;
                  spi_sck  <= 1'b0;
                  phase    <= '0;
                  bit_cnt  <= '0;
               end else if (cnt == CntW'(BusyTimeout - 1)) begin
                  busy_timeout <= 1'b1;
                  state        <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_SHIFT: begin
               if (phase == PhW'(SckDiv - 1)) begin
                  // SDO is captured on the same edge that raises SCK.
                  spi_sck <= 1'b1;
                  shreg   <= {shreg[DataBits-2:0], spi_sdo};
                  phase   <= phase + 1'b1;
               end else if (phase == PhW'(2 * SckDiv - 1)) begin
                  spi_sck <= 1'b0;
                  phase   <= '0;
                  if (bit_cnt == BitW'(DataBits - 1)) begin
                     spi_cs_n <= 1'b1;
                     state    <= ST_PUSH;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            ST_PUSH: begin
               if (fifo_full && !fifo_pop && dropped_count != '1)
                  dropped_count <= dropped_count + 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   sync_fifo #(
      .Width (SampleWidth),
      .Depth (FifoDepth)
   ) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .push    (fifo_push),
      .din     (push_data),
      .full    (fifo_full),
      .pop     (fifo_pop),
      .dout    (fifo_dout),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

endmodule

// File: tb/tb_adc_spi_streamer.sv
// Scoreboard bench for adc_spi_streamer with a behavioural ADC model.
module tb_adc_spi_streamer;
   import adc_pkg::*;

   localparam int DB = 24;
   localparam int SD = 2;
   localparam int CC = 4;
   localparam int BT = 1024;
   localparam int FD = 4;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        enable = 1'b0;
   logic        trigger = 1'b0;
   logic        adc_busy = 1'b0;
   logic        spi_sdo = 1'b0;
   logic        adc_cnv;
   logic        spi_cs_n;
   logic        spi_sck;
   logic [31:0] dropped_count;
   logic        busy_timeout;
   logic [2:0]  fifo_level;

   adc_spi_streamer_if axis();

   always #5 aclk = ~aclk;

   adc_spi_streamer #(
      .DataBits    (DB),
      .SckDiv      (SD),
      .CnvCycles   (CC),
      .BusyTimeout (BT),
      .FifoDepth   (FD)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .enable        (enable),
      .trigger       (trigger),
      .adc_cnv       (adc_cnv),
      .adc_busy      (adc_busy),
      .spi_cs_n      (spi_cs_n),
      .spi_sck       (spi_sck),
      .spi_sdo       (spi_sdo),
      .m_axis_data   (axis),
      .dropped_count (dropped_count),
      .busy_timeout  (busy_timeout),
      .fifo_level    (fifo_level)
   );

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   int          exp_drop = 0;

   logic [DB-1:0] next_sample = '0;
   logic [DB-1:0] cur_sample = '0;
   int          busy_hold = 10;
   bit          busy_forever = 1'b0;
   int          busy_left = 0;
   logic        prev_cnv = 1'b0, prev_sck = 1'b0, prev_cs = 1'b1;
   int          bit_idx = 0, rises = 0, cs_low = 0, cnv_high = 0;
   int          cnv_pulses = 0, frames = 0, beats = 0, tvalid_cycles = 0;
   bit          rand_ready = 1'b0;
   logic        hold_prev = 1'b0;
   logic [31:0] prev_tdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // Two's-complement value of an ADC code, expressed as a 32-bit word.
   function automatic logic [31:0] sext(input logic [DB-1:0] s);
      longint v;
      v = longint'(s);
      if (v >= (longint'(1) << (DB - 1))) v = v - (longint'(1) << DB);
      return 32'(v);
   endfunction

   // ADC model: BUSY after CNV, SDO MSB-first changing on SCK falls; frame-end bookkeeping.
   always @(negedge aclk) begin
      if (adc_cnv) cnv_high++;
      if (adc_cnv && !prev_cnv) begin
         cnv_pulses++;
         cur_sample = next_sample;
         adc_busy   = 1'b1;
         busy_left  = busy_hold;
      end else if (adc_busy && !busy_forever) begin
         if (busy_left > 0) busy_left--;
         else adc_busy = 1'b0;
      end
      if (!adc_cnv && prev_cnv) begin
         if (aresetn) check("cnv_width", cnv_high, CC);
         cnv_high = 0;
      end
      if (!spi_cs_n) begin
         cs_low++;
         if (spi_sck && !prev_sck) rises++;
         if (!spi_sck && prev_sck) bit_idx++;
      end else begin
         bit_idx = 0;
      end
      if (spi_cs_n && !prev_cs && aresetn) begin
         frames++;
         check("cs_low_cycles", cs_low, 2 * SD * DB);
         check("sck_rises", rises, DB);
         if (exp_q.size() >= FD) exp_drop++;
         else exp_q.push_back(sext(cur_sample));
      end
      if (spi_cs_n) begin
         cs_low = 0;
         rises  = 0;
      end
      spi_sdo  = (bit_idx < DB) ? cur_sample[DB-1-bit_idx] : 1'b0;
      prev_cnv = adc_cnv;
      prev_sck = spi_sck;
      prev_cs  = spi_cs_n;
   end

   // Monitor: pops the scoreboard on every accepted beat.
   always @(negedge aclk) begin
      if (aresetn) begin
         if (axis.tvalid) tvalid_cycles++;
         if (hold_prev && axis.tvalid) check("tdata_stable", axis.tdata, prev_tdata);
         if (axis.tvalid && axis.tready) begin
            beats++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat actual=0x%08h required=no_beat", axis.tdata);
            end else begin
               check("tdata", axis.tdata, exp_q.pop_front());
            end
         end
         hold_prev  = axis.tvalid && !axis.tready;
         prev_tdata = axis.tdata;
      end else begin
         hold_prev = 1'b0;
      end
   end

   // Random backpressure while enabled.
   always @(posedge aclk) begin
      if (rand_ready) begin
         #1;
         axis.tready = 1'($urandom_range(0, 1));
      end
   end

   task automatic pulse_trigger();
      @(posedge aclk); #1 trigger = 1'b1;
      @(posedge aclk); #1 trigger = 1'b0;
   endtask

   task automatic do_read(input logic [DB-1:0] s, input int hold);
      next_sample = s;
      busy_hold   = hold;
      pulse_trigger();
   endtask

   task automatic wait_frame(input string name);
      int f0 = frames;
      int n  = 0;
      while (frames == f0 && n < 3000) begin
         @(posedge aclk);
         n++;
      end
      if (frames == f0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_frame required=frame", name);
      end
      repeat (4) @(posedge aclk);
      #1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, p0, tv0, n;
      axis.tready = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      check("rst_cnv", adc_cnv, 0);
      check("rst_cs_n", spi_cs_n, 1);
      check("rst_sck", spi_sck, 0);
      check("rst_tvalid", axis.tvalid, 0);
      check("rst_dropped", dropped_count, 0);
      check("rst_timeout", busy_timeout, 0);
      check("rst_level", fifo_level, 0);
      aresetn = 1'b1;
      enable  = 1'b1;
      axis.tready = 1'b1;

      // Negative full-scale edge code.
      b0 = beats;
      do_read(24'h800001, 20);
      wait_frame("t1");
      check("t1_beats", beats - b0, 1);
      check("t1_level", fifo_level, 0);

      // Positive full scale, single-cycle valid.
      tv0 = tvalid_cycles;
      do_read(24'h7FFFFF, 8);
      wait_frame("t2");
      check("t2_tvalid_cycles", tvalid_cycles - tv0, 1);
      check("t2_level", fifo_level, 0);

      // Random codes and busy times under random backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         do_read(DB'($urandom), int'($urandom_range(4, 40)));
         wait_frame("rand");
      end
      rand_ready = 1'b0;
      repeat (2) @(posedge aclk);
      #2 axis.tready = 1'b1;
      repeat (5) @(posedge aclk);
      #1;
      check("rand_drained", exp_q.size(), 0);

      // Overflow: six reads into a stalled four-deep FIFO.
      axis.tready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         do_read(DB'($urandom), int'($urandom_range(4, 30)));
         wait_frame("t3");
      end
      check("t3_level", fifo_level, FD);
      check("t3_dropped", dropped_count, 2);
      check("t3_dropped_model", dropped_count, exp_drop);
      check("t3_tvalid", axis.tvalid, 1);
      b0 = beats;
      axis.tready = 1'b1;
      repeat (10) @(posedge aclk);
      #1;
      check("t3_beats", beats - b0, FD);
      check("t3_level_after", fifo_level, 0);

      // BUSY stuck high.
      busy_forever = 1'b1;
      p0 = frames;
      b0 = beats;
      do_read(DB'($urandom), 0);
      n = 0;
      while (!busy_timeout && n < 1300) begin
         @(posedge aclk);
         n++;
      end
      #1;
      check("t4_timeout", busy_timeout, 1);
      check("t4_not_early", n >= BT - 4, 1);
      busy_forever = 1'b0;
      repeat (5) @(posedge aclk);
      #1;
      check("t4_no_frame", frames - p0, 0);
      check("t4_no_beat", beats - b0, 0);
      check("t4_cs_idle", spi_cs_n, 1);
      do_read(DB'($urandom), 12);
      wait_frame("t4b");
      check("t4_recover_beat", beats - b0, 1);
      check("t4_sticky", busy_timeout, 1);

      // Triggers during SHIFT and while disabled are ignored.
      p0 = cnv_pulses;
      b0 = beats;
      do_read(DB'($urandom), 10);
      n = 0;
      while (spi_cs_n && n < 200) begin
         @(posedge aclk);
         n++;
      end
      repeat (10) @(posedge aclk);
      pulse_trigger();
      pulse_trigger();
      wait_frame("t5");
      repeat (20) @(posedge aclk);
      #1;
      check("t5_cnv_pulses", cnv_pulses - p0, 1);
      check("t5_beats", beats - b0, 1);
      enable = 1'b0;
      p0 = cnv_pulses;
      pulse_trigger();
      repeat (20) @(posedge aclk);
      #1;
      check("t5_disabled_cnv", cnv_pulses - p0, 0);
      check("t5_disabled_pin", adc_cnv, 0);
      enable = 1'b1;

      // Asynchronous reset in the middle of SHIFT.
      axis.tready = 1'b0;
      do_read(DB'($urandom), 10);
      wait_frame("t6a");
      check("t6_tvalid_before", axis.tvalid, 1);
      do_read(DB'($urandom), 10);
      n = 0;
      while (rises < DB / 2 && n < 500) begin
         @(posedge aclk);
         n++;
      end
      @(posedge aclk);
      #3 aresetn = 1'b0;
      exp_q.delete();
      exp_drop = 0;
      #1;
      check("t6_cs_n", spi_cs_n, 1);
      check("t6_sck", spi_sck, 0);
      check("t6_tvalid", axis.tvalid, 0);
      check("t6_level", fifo_level, 0);
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
      check("t6_dropped", dropped_count, 0);
      check("t6_timeout", busy_timeout, 0);
      axis.tready = 1'b1;
      b0 = beats;
      do_read(DB'($urandom), 15);
      wait_frame("t6b");
      check("t6_beat", beats - b0, 1);
      check("final_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_spi_streamer.md
Name: adc_spi_streamer

Overview:
- Upstream neighbour of the sample packetizer. Drives a conversion-start/SPI-read ADC: pulses CNV, waits for BUSY, then clocks out one DataBits-wide sample over SPI.
- Each sample is sign-extended to 32 bits, buffered in a small FWFT FIFO, and presented as an AXI-Stream manager that feeds the packetizer's data subordinate.
- Counts samples dropped on FIFO overflow.

Parameters:
DataBits, 24, ADC sample width (8..32), MSB first on SDO
SckDiv, 2, SCK half-period in aclk cycles (>=1)
CnvCycles, 4, CNV high time in aclk cycles (>=1)
BusyTimeout, 1024, max aclk cycles spent in WAIT_BUSY before abort
FifoDepth, 4, output FIFO entries (power of two, >=2)

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous, active-low
enable  in  1  high: triggers accepted; low: new triggers ignored (in-flight read completes)
trigger  in  1  single-cycle request to start one conversion
adc_cnv  out  1  ADC conversion start
adc_busy  in  1  ADC busy (high while converting); synchronised internally with 2 flops
spi_cs_n  out  1  SPI chip select, active-low
spi_sck  out  1  SPI clock, idle low
spi_sdo  in  1  ADC serial data
m_axis_data_tdata  out  32  sign-extended sample
m_axis_data_tvalid  out  1  FIFO non-empty
m_axis_data_tready  in  1  downstream ready
dropped_count  out  32  saturating count of samples lost to FIFO full
busy_timeout  out  1  sticky flag; cleared only by reset
fifo_level  out  $clog2(FifoDepth)+1  current FIFO occupancy

Behaviour:
- Reset values: adc_cnv=0, spi_cs_n=1, spi_sck=0, tvalid=0, dropped_count=0, busy_timeout=0, fifo_level=0, FSM=IDLE, FIFO emptied. Reset mid-read aborts the read immediately; no partial sample is pushed.
- FSM states: IDLE, CNV, WAIT_BUSY, SHIFT, PUSH.
- IDLE: if trigger && enable, go to CNV with adc_cnv=1 in the next cycle. Triggers in any other state are ignored and not counted.
- CNV: hold adc_cnv=1 for exactly CnvCycles cycles, then drop it and go to WAIT_BUSY.
- WAIT_BUSY: wait for the synchronised busy to go low. BUSY may still read low for a few cycles after CNV because of synchroniser latency, so busy low is only honoured once 3 cycles have elapsed in this state.
  - Busy low: go to SHIFT and assert spi_cs_n=0.
  - BusyTimeout cycles elapse first: set busy_timeout=1 and return to IDLE; nothing is pushed.
- SHIFT: DataBits SCK periods, each SckDiv cycles low followed by SckDiv cycles high.
  - spi_sdo is sampled into the shift register in the aclk cycle where spi_sck rises.
  - After the last high half, spi_sck=0 and spi_cs_n=1 in the same cycle; go to PUSH.
- PUSH (one cycle):
  - FIFO not full: write {{(32-DataBits){sample[DataBits-1]}}, sample}.
  - FIFO full: drop the sample; dropped_count += 1, saturating at 0xFFFF_FFFF.
  - Then return to IDLE.
- Throughput: one sample per 1 + CnvCycles + busy wait + 2*SckDiv*DataBits + 1 cycles.
- FIFO is first-word-fall-through:
  - tvalid = level != 0.
  - tdata = head entry, stable while tvalid && !tready.
  - A word pushed in cycle N is visible as tvalid in cycle N+1.
  - Pop on tvalid && tready.
  - Simultaneous push and pop while full: the pop frees space, so the push succeeds and nothing is dropped. While empty: no bypass; the word appears in the next cycle.
  - Pointers wrap modulo FifoDepth. level = wr_count - rd_count using one extra bit.
- enable deasserted mid-read: the read completes and pushes normally.

Decomposition:
- Shared package adc_pkg: FSM state enum, SampleWidth=32, synchroniser depth constant.
- Sub-module sync_fifo (FWFT, params Width, Depth; ports: push, din, full, pop, dout, empty, level). Reusable by other stream stages.

Test Plan:
1. DataBits=24, SckDiv=2: trigger; ADC model holds busy 20 cycles, then shifts 0x800001 -> exactly one beat tdata=0xFF800001; spi_cs_n low for 96 cycles; 24 rising SCK edges.
2. Sample 0x7FFFFF with tready=1 -> tdata=0x007FFFFF; tvalid high for exactly 1 cycle; fifo_level returns to 0.
3. tready=0, 6 triggers with FifoDepth=4 -> fifo_level=4, dropped_count=2; release tready -> first 4 samples out in order, none duplicated.
4. busy held high forever -> after BusyTimeout cycles busy_timeout=1, FSM back in IDLE, no beat; the next trigger with a normal ADC still produces a sample.
5. trigger pulsed during SHIFT -> ignored: exactly one sample and one CNV pulse; enable=0 with trigger -> adc_cnv stays 0.
6. aresetn asserted while halfway through SHIFT -> spi_cs_n=1, spi_sck=0, tvalid=0 asynchronously; after release, a new trigger yields a correct full sample.
